// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// No logic of its own; imported by the checker and its latency pipe.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_CMP,
    ST_FIN
  } state_t;

  localparam logic        ADDR_ID          = 1'b0;
  localparam logic        ADDR_TS          = 1'b1;
  localparam int unsigned MAX_READ_LATENCY = 3;

  function automatic logic words_match(input logic [31:0] id_word,
                                       input logic [31:0] ts_word,
                                       input logic [31:0] exp_id,
                                       input logic [31:0] exp_ts,
                                       input logic        check_ts);
    return (id_word == exp_id) && (!check_ts || (ts_word == exp_ts));
  endfunction

endpackage

// File: rtl/sysid_rd_latency_pipe.sv
// Delays the read-accept pulse by DEPTH cycles to mark when readdata is valid.
// Latency DEPTH cycles (0 = combinational bypass); no backpressure, one bit per stage.
module sysid_rd_latency_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept,
  output logic strobe
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign strobe = accept;
    end else begin : g_shift
      logic [DEPTH-1:0] vld;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld <= '0;
        end else begin
          vld[0] <= accept;
          for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
          end
        end
      end

      assign strobe = vld[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads system ID and build timestamp from the ID slave and checks them at boot.
// Done 4 cycles after start with no stalls; each read held until accepted, aborted after TIMEOUT_CYCLES stalls.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1417892138,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t STALL_LIMIT = cnt_t'(TIMEOUT_CYCLES - 1);

  state_t state;
  cnt_t   stall_cnt;
  logic   accept;
  logic   cap_stb;

  assign accept = avm_read && !avm_waitrequest;

  generate
    if (LAT == 0) begin : g_no_lat
      assign cap_stb = accept;
    end else begin : g_lat
      sysid_rd_latency_pipe #(
        .DEPTH (LAT)
      ) u_lat_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .accept  (accept),
        .strobe  (cap_stb)
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      stall_cnt   <= '0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      // Capture strobe lines up with the read that produced it: RD_* when LAT=0, LAT_* otherwise.
      if (cap_stb && (state == ST_RD_ID || state == ST_LAT_ID)) id_value <= avm_readdata;
      if (cap_stb && (state == ST_RD_TS || state == ST_LAT_TS)) ts_value <= avm_readdata;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RD_ID;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            stall_cnt   <= '0;
          end
        end

        ST_RD_ID, ST_RD_TS: begin
          if (avm_waitrequest) begin
            if (stall_cnt == STALL_LIMIT) begin
              avm_read  <= 1'b0;
              timeout   <= 1'b1;
              pass      <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              stall_cnt <= '0;
              state     <= ST_FIN;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else begin
            stall_cnt <= '0;
            if (LAT == 0) begin
              if (state == ST_RD_ID) begin
                avm_address <= ADDR_TS;
                state       <= ST_RD_TS;
              end else begin
                avm_read <= 1'b0;
                state    <= ST_CMP;
              end
            end else begin
              avm_read <= 1'b0;
              state    <= (state == ST_RD_ID) ? ST_LAT_ID : ST_LAT_TS;
            end
          end
        end

        ST_LAT_ID: begin
          if (cap_stb) begin
            avm_read    <= 1'b1;
            avm_address <= ADDR_TS;
            state       <= ST_RD_TS;
          end
        end

        ST_LAT_TS: begin
          if (cap_stb) state <= ST_CMP;
        end

        ST_CMP: begin
          pass  <= words_match(id_value, ts_value, EXPECTED_ID, EXPECTED_TIMESTAMP, CHECK_TIMESTAMP);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_FIN;
        end

        ST_FIN: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Two checker instances (latency 0 with timestamp check, latency 2 ID-only) against an Avalon slave model.
// A scoreboard queue per instance holds expected results; a negedge monitor pops them when done rises.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1417892138;
  localparam int          T      = 16;
  localparam int          STUCK  = 1000;

  typedef struct {
    logic        pass;
    logic        to;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
    int          reads;
  } exp_t;

  logic clock = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   blocks_done = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL [dut%0d] %s: got 0x%0h, required 0x%0h", inst, nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L   = (g == 1) ? 2 : 0;
    localparam int LI  = (L == 0) ? 0 : L - 1;
    localparam bit CHK = (g == 0);

    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, timeout;
    logic [31:0] id_value, ts_value;

    logic [31:0] mem_id = '0;
    logic [31:0] mem_ts = '0;
    logic        stall_addr = 1'b0;
    int          stall_n = 0;
    int          wait_cnt = 0;
    int          acc_cnt = 0;
    int          acc_base = 0;
    int          t0 = 0;
    bit          vpipe [4];
    logic [31:0] dpipe [4];
    logic [31:0] junk = 32'hA5A5_5A5A;
    logic        junk_w = 1'b0;
    exp_t        exp_q [$];

    int   run_len = 0;
    logic pr_read = 1'b0, pr_wait = 1'b0, pr_addr = 1'b0, pr_done = 1'b0, pr_rst = 1'b0;

    sysid_boot_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .CHECK_TIMESTAMP    (CHK),
      .READ_LATENCY       (L),
      .TIMEOUT_CYCLES     (T)
    ) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value)
    );

    // Slave model: stalls the chosen address stall_n cycles; data appears L cycles after accept.
    always_comb begin
      avm_waitrequest = avm_read ? ((avm_address == stall_addr) && (wait_cnt < stall_n)) : junk_w;
      if (L == 0)
        avm_readdata = (avm_read && !avm_waitrequest) ? (avm_address ? mem_ts : mem_id) : junk;
      else
        avm_readdata = vpipe[LI] ? dpipe[LI] : junk;
    end

    always @(posedge clock) begin
      junk     <= $urandom;
      junk_w   <= 1'($urandom_range(0, 1));
      wait_cnt <= (avm_read && avm_waitrequest) ? wait_cnt + 1 : 0;
      vpipe[0] <= avm_read && !avm_waitrequest;
      dpipe[0] <= avm_address ? mem_ts : mem_id;
      for (int i = 1; i < 4; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
      if (avm_read && !avm_waitrequest) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clock) begin : mon
      exp_t e;
      if (reset_n && pr_rst) begin
        chk(g, "read_only_when_busy", avm_read && !busy, 1'b0);
        if (pr_read && pr_wait) begin
          if (run_len < T) begin
            chk(g, "stall_hold_read", avm_read, 1'b1);
            chk(g, "stall_hold_addr", avm_address, pr_addr);
          end else begin
            chk(g, "timeout_drop_read", avm_read, 1'b0);
          end
        end
        if (avm_read && !avm_waitrequest)
          chk(g, "rd_addr_order", avm_address, (acc_cnt - acc_base) == 1);
        for (int i = 0; i < L; i++)
          if (vpipe[i]) chk(g, "single_outstanding", avm_read, 1'b0);
        if (done && !pr_done) begin
          if (exp_q.size() == 0) begin
            chk(g, "unexpected_done", done, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk(g, "pass", pass, e.pass);
            chk(g, "timeout", timeout, e.to);
            chk(g, "id_value", id_value, e.id);
            chk(g, "ts_value", ts_value, e.ts);
            chk(g, "done_latency", cyc - t0, e.lat);
            chk(g, "reads_issued", acc_cnt - acc_base, e.reads);
            chk(g, "busy_at_done", busy, 1'b0);
          end
        end
      end
      run_len <= (reset_n && avm_read && avm_waitrequest) ? run_len + 1 : 0;
      pr_read <= avm_read;
      pr_wait <= avm_waitrequest;
      pr_addr <= avm_address;
      pr_done <= done;
      pr_rst  <= reset_n;
    end

    initial begin : stim
      logic [31:0] id_w, ts_w, cap_id, cap_ts;
      logic        sa;
      int          sn, k;
      bit          mid, to;
      exp_t        e;
      cap_id = '0;
      cap_ts = '0;
      #1 reset_n = 1'b0;
      #2;
      chk(g, "reset_ctrl", {avm_read, avm_address, busy, done, pass, timeout}, 6'b0);
      chk(g, "reset_id", id_value, 32'd0);
      chk(g, "reset_ts", ts_value, 32'd0);
      @(negedge clock) reset_n = 1'b1;

      for (int n = 0; n < 18; n++) begin
        id_w = EXP_ID; ts_w = EXP_TS; sa = 1'b1; sn = 0; mid = 1'b0;
        case (n)
          0: ;
          1: ts_w = 32'h1234_5678;
          2: sn = 5;
          3: sn = STUCK;
          4: begin sa = 1'b0; sn = STUCK; end
          5: begin sa = 1'b0; sn = 2; mid = 1'b1; end
          6: id_w = 32'hDEAD_BEEF;
          7: ;
          default: begin
            id_w = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            ts_w = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            sa   = 1'($urandom_range(0, 1));
            sn   = ($urandom_range(0, 7) == 0) ? STUCK : $urandom_range(0, 4);
            mid  = 1'($urandom_range(0, 1));
          end
        endcase

        if (n == 7) begin
          // Abort a check while it is stalled in the timestamp read.
          mem_id = EXP_ID; mem_ts = EXP_TS; stall_addr = 1'b1; stall_n = 6;
          @(negedge clock);
          acc_base = acc_cnt; t0 = cyc; start = 1'b1;
          @(negedge clock) start = 1'b0;
          repeat (2 + L) @(negedge clock);
          chk(g, "rd_ts_before_reset", {avm_read, avm_address}, 2'b11);
          #2 reset_n = 1'b0;
          #1;
          chk(g, "midread_reset_ctrl", {avm_read, avm_address, busy, done, pass, timeout}, 6'b0);
          chk(g, "midread_reset_data", {id_value, ts_value}, 64'd0);
          cap_id = '0; cap_ts = '0;
          @(negedge clock) #2 reset_n = 1'b1;
          repeat (2) @(negedge clock);
        end

        to = (sn >= T);
        if (!to || sa) cap_id = id_w;
        if (!to) cap_ts = ts_w;
        e.pass  = !to && (id_w == EXP_ID) && (!CHK || (ts_w == EXP_TS));
        e.to    = to;
        e.id    = cap_id;
        e.ts    = cap_ts;
        e.lat   = to ? ((sa ? 2 + L : 1) + T) : (4 + 2 * L + sn);
        e.reads = to ? (sa ? 1 : 0) : 2;

        mem_id = id_w; mem_ts = ts_w; stall_addr = sa; stall_n = sn;
        exp_q.push_back(e);
        @(negedge clock);
        acc_base = acc_cnt; t0 = cyc; start = 1'b1;
        @(negedge clock) start = 1'b0;
        chk(g, "busy_after_start", {busy, done}, 2'b10);
        if (mid) begin
          @(negedge clock) start = 1'b1;
          chk(g, "busy_at_mid_start", busy, 1'b1);
          @(negedge clock) start = 1'b0;
        end

        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
          @(negedge clock);
          k++;
        end
        if (exp_q.size() != 0) begin
          chk(g, "done_within_budget", 1'b0, 1'b1);
          exp_q.delete();
        end
        repeat (2) @(negedge clock);
      end
      blocks_done++;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && blocks_done < 2; k++) @(negedge clock);
    if (blocks_done < 2) chk(-1, "run_budget", blocks_done, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
